func_ret_rob: RTL and testbench

- Return-path reorder buffer directly downstream of the function arbiter.
- The caller allocates a call-sequence tag per issued call. The arbiter returns RET_DW results tagged with that sequence, possibly out of order across HW instances.
- This block stores the results and releases them to the caller strictly in allocation order.
- There is one instance per caller port; ROB depth is 1<<CALL_SEQ_W.

---
 rtl/func_arbiter_pkg.sv | 23 ++
 rtl/func_ret_rob.sv | 111 +++++++++++
 tb/tb_func_ret_rob.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/func_arbiter_pkg.sv
// Shared types for the function arbiter return path.
// Holds the ROB entry layout and the pointer-full helper used by func_ret_rob.
package func_arbiter_pkg;

    localparam int RET_DW    = 32;
    localparam int PTR_MAX_W = 16;

    typedef struct packed {
        logic              alloc;
        logic              done;
        logic [RET_DW-1:0] dat;
    } rob_entry_t;

    // Pointers carry a wrap bit above the index; full means only that bit differs.
    function automatic logic rob_full(input logic [PTR_MAX_W-1:0] head,
                                      input logic [PTR_MAX_W-1:0] tail,
                                      input int                   seq_w);
        logic [PTR_MAX_W-1:0] wrap_only;
        wrap_only = {{(PTR_MAX_W-1){1'b0}}, 1'b1} << seq_w;
        return (head ^ tail) == wrap_only;
    endfunction

endpackage

// File: rtl/func_ret_rob.sv
// Return-path reorder buffer: holds out-of-order arbiter returns and
// releases them to the caller strictly in tag-allocation order.
module func_ret_rob #(
    parameter  int CALL_SEQ_W = 2,
    localparam int ROB_W      = 1 << CALL_SEQ_W,
    parameter  int RET_DW     = func_arbiter_pkg::RET_DW
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  alloc_req,
    output logic                  alloc_rdy,
    output logic [CALL_SEQ_W-1:0] alloc_seq,
    input  logic                  ret_vld,
    input  logic [CALL_SEQ_W-1:0] ret_seq,
    input  logic [RET_DW-1:0]     ret_dat,
    output logic                  out_vld,
    output logic [RET_DW-1:0]     out_dat,
    output logic [CALL_SEQ_W-1:0] out_seq,
    input  logic                  out_rdy,
    output logic [CALL_SEQ_W:0]   occupancy,
    output logic                  err
);
    import func_arbiter_pkg::*;

    localparam int PTR_W = CALL_SEQ_W + 1;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [ROB_W-1:0]      alloc_q, alloc_d;
    logic [ROB_W-1:0]      done_q, done_d;
    logic                  err_q, err_d;
    logic [RET_DW-1:0]     data_q [ROB_W];

    logic [CALL_SEQ_W-1:0] head_idx;
    logic [CALL_SEQ_W-1:0] tail_idx;
    logic                  do_alloc;
    logic                  do_pop;
    logic                  ret_legal;
    rob_entry_t            head_ent;

    assign head_idx = head_q[CALL_SEQ_W-1:0];
    assign tail_idx = tail_q[CALL_SEQ_W-1:0];
    assign head_ent = {alloc_q[head_idx], done_q[head_idx], data_q[head_idx]};

    // alloc_rdy looks only at registered pointers, so a same-cycle pop never frees a slot early.
    assign alloc_rdy = !rob_full(PTR_MAX_W'(head_q), PTR_MAX_W'(tail_q), CALL_SEQ_W);
    assign alloc_seq = tail_idx;
    assign out_vld   = head_ent.alloc & head_ent.done;
    assign out_dat   = head_ent.dat;
    assign out_seq   = head_idx;
    assign occupancy = tail_q - head_q;
    assign err       = err_q;

    assign do_alloc  = alloc_req & alloc_rdy;
    assign do_pop    = out_vld & out_rdy;
    assign ret_legal = ret_vld & alloc_q[ret_seq] & ~done_q[ret_seq];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        alloc_d = alloc_q;
        done_d  = done_q;
        err_d   = 1'b0;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            alloc_d = '0;
            done_d  = '0;
        end else begin
            err_d = ret_vld & ~ret_legal;
            if (ret_legal) begin
                done_d[ret_seq] = 1'b1;
            end
            // A legal return never targets the popped head (already done) nor the tail (not yet allocated).
            if (do_pop) begin
                alloc_d[head_idx] = 1'b0;
                done_d[head_idx]  = 1'b0;
                head_d            = head_q + 1'b1;
            end
            if (do_alloc) begin
                alloc_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                tail_d            = tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ret_legal && !flush) begin
            data_q[ret_seq] <= ret_dat;
        end
    end

endmodule

// File: tb/tb_func_ret_rob.sv
// Self-checking bench for func_ret_rob: step table, directed corner
// sequences, and a negedge reference model with an in-order tag scoreboard.
module tb_func_ret_rob;

    localparam int SW = 2;
    localparam int DW = 32;

    logic          clk;
    logic          rstn;
    logic          flush;
    logic          alloc_req;
    logic          alloc_rdy;
    logic [SW-1:0] alloc_seq;
    logic          ret_vld;
    logic [SW-1:0] ret_seq;
    logic [DW-1:0] ret_dat;
    logic          out_vld;
    logic [DW-1:0] out_dat;
    logic [SW-1:0] out_seq;
    logic          out_rdy;
    logic [SW:0]   occupancy;
    logic          err;

    int checks = 0;
    int errors = 0;

    func_ret_rob #(.CALL_SEQ_W(SW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .alloc_req (alloc_req),
        .alloc_rdy (alloc_rdy),
        .alloc_seq (alloc_seq),
        .ret_vld   (ret_vld),
        .ret_seq   (ret_seq),
        .ret_dat   (ret_dat),
        .out_vld   (out_vld),
        .out_dat   (out_dat),
        .out_seq   (out_seq),
        .out_rdy   (out_rdy),
        .occupancy (occupancy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard (negedge) ----------------
    int          m_head;
    int          m_tail;
    bit          m_alloc [4];
    bit          m_done  [4];
    logic [31:0] m_dat   [4];
    bit          m_err;
    int          sb [$];

    task automatic model_reset();
        m_head = 0;
        m_tail = 0;
        m_err  = 0;
        for (int i = 0; i < 4; i++) begin
            m_alloc[i] = 0;
            m_done[i]  = 0;
        end
        sb.delete();
    endtask

    task automatic mon_cycle();
        int h, t, occ, ft;
        bit mvld, full, pop, alc, legal;
        if (!rstn) begin
            model_reset();
            return;
        end
        h    = m_head % 4;
        t    = m_tail % 4;
        occ  = (m_tail - m_head + 8) % 8;
        full = (occ == 4);
        mvld = m_alloc[h] && m_done[h];
        chk("m_alloc_rdy", alloc_rdy, !full);
        chk("m_occupancy", occupancy, occ);
        chk("m_out_vld", out_vld, mvld);
        chk("m_err", err, m_err);
        chk("m_alloc_seq", alloc_seq, t);
        chk("m_out_seq", out_seq, h);
        if (mvld) chk("m_out_dat", out_dat, m_dat[h]);
        pop   = mvld && out_rdy;
        alc   = alloc_req && !full;
        legal = ret_vld && m_alloc[ret_seq] && !m_done[ret_seq];
        if (flush) begin
            model_reset();
            return;
        end
        m_err = ret_vld && !legal;
        if (legal) begin
            m_done[ret_seq] = 1;
            m_dat[ret_seq]  = ret_dat;
        end
        if (pop) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                ft = sb.pop_front();
                chk("sb_out_seq", out_seq, ft);
                chk("sb_out_dat", out_dat, m_dat[ft]);
            end
            m_alloc[h] = 0;
            m_done[h]  = 0;
            m_head     = (m_head + 1) % 8;
        end
        if (alc) begin
            m_alloc[t] = 1;
            m_done[t]  = 0;
            sb.push_back(t);
            m_tail = (m_tail + 1) % 8;
        end
    endtask

    always @(negedge clk) mon_cycle();

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit a, input bit rv, input int rs, input logic [31:0] rd,
                         input bit ordy, input bit fl);
        alloc_req = a;
        ret_vld   = rv;
        ret_seq   = rs[SW-1:0];
        ret_dat   = rd;
        out_rdy   = ordy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string nm, input bit ovld, input logic [31:0] odat,
                            input int occ, input bit e_err);
        chk({nm, "_out_vld"}, out_vld, ovld);
        if (ovld) chk({nm, "_out_dat"}, out_dat, odat);
        chk({nm, "_occ"}, occupancy, occ);
        chk({nm, "_err"}, err, e_err);
    endtask

    typedef struct {
        bit          a;
        bit          rv;
        int          rs;
        logic [31:0] rd;
        bit          ordy;
        bit          e_rdy;
        int          e_seq;
        bit          e_ovld;
        logic [31:0] e_odat;
        int          e_occ;
        bit          e_err;
    } vec_t;

    function automatic vec_t mk(bit a, bit rv, int rs, logic [31:0] rd, bit ordy,
                                bit e_rdy, int e_seq, bit e_ovld, logic [31:0] e_odat,
                                int e_occ, bit e_err);
        vec_t v;
        v.a = a; v.rv = rv; v.rs = rs; v.rd = rd; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_seq = e_seq; v.e_ovld = e_ovld; v.e_odat = e_odat;
        v.e_occ = e_occ; v.e_err = e_err;
        return v;
    endfunction

    function automatic int stag(int k);
        return (1 + k) % 4;
    endfunction

    vec_t vt [12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // expected outputs are those visible after the clock edge of each row
        vt[0]  = mk(1, 0, 0, 32'h0,  0, 1, 1, 0, 32'h0,  1, 0);
        vt[1]  = mk(1, 0, 0, 32'h0,  0, 1, 2, 0, 32'h0,  2, 0);
        vt[2]  = mk(0, 1, 2, 32'h55, 0, 1, 2, 0, 32'h0,  2, 1);
        vt[3]  = mk(0, 0, 0, 32'h0,  0, 1, 2, 0, 32'h0,  2, 0);
        vt[4]  = mk(1, 0, 0, 32'h0,  0, 1, 3, 0, 32'h0,  3, 0);
        vt[5]  = mk(1, 0, 0, 32'h0,  0, 0, 0, 0, 32'h0,  4, 0);
        vt[6]  = mk(0, 1, 0, 32'hA0, 1, 0, 0, 1, 32'hA0, 4, 0);
        vt[7]  = mk(0, 1, 1, 32'hA1, 1, 1, 0, 1, 32'hA1, 3, 0);
        vt[8]  = mk(0, 1, 1, 32'hFF, 0, 1, 0, 1, 32'hA1, 3, 1);
        vt[9]  = mk(0, 1, 2, 32'hA2, 1, 1, 0, 1, 32'hA2, 2, 0);
        vt[10] = mk(0, 1, 3, 32'hA3, 1, 1, 0, 1, 32'hA3, 1, 0);
        vt[11] = mk(0, 0, 0, 32'h0,  1, 1, 0, 0, 32'h0,  0, 0);

        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_alloc_rdy", alloc_rdy, 1);
        chk("rst_alloc_seq", alloc_seq, 0);
        chk("rst_out_seq", out_seq, 0);
        expect_o("rst", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].a, vt[i].rv, vt[i].rs, vt[i].rd, vt[i].ordy, 0);
            step();
            chk($sformatf("tbl%0d_alloc_rdy", i), alloc_rdy, vt[i].e_rdy);
            chk($sformatf("tbl%0d_alloc_seq", i), alloc_seq, vt[i].e_seq);
            expect_o($sformatf("tbl%0d", i), vt[i].e_ovld, vt[i].e_odat, vt[i].e_occ, vt[i].e_err);
        end

        // out-of-order returns: nothing leaves until tag 0 lands
        drive(1, 0, 0, 0, 0, 0);
        repeat (4) step();
        chk("ooo_full_rdy", alloc_rdy, 0);
        drive(0, 1, 3, 32'hD3, 1, 0); step(); expect_o("ooo_r3", 0, 0, 4, 0);
        drive(0, 1, 1, 32'hD1, 1, 0); step(); expect_o("ooo_r1", 0, 0, 4, 0);
        drive(0, 1, 2, 32'hD2, 1, 0); step(); expect_o("ooo_r2", 0, 0, 4, 0);
        drive(0, 1, 0, 32'hD0, 1, 0); step(); expect_o("ooo_r0", 1, 32'hD0, 4, 0);
        drive(0, 0, 0, 0, 1, 0);
        step(); expect_o("ooo_p1", 1, 32'hD1, 3, 0);
        step(); expect_o("ooo_p2", 1, 32'hD2, 2, 0);
        step(); expect_o("ooo_p3", 1, 32'hD3, 1, 0);
        step(); expect_o("ooo_p4", 0, 0, 0, 0);

        // backpressure while full, duplicate return, pop with alloc held
        drive(1, 0, 0, 0, 0, 0);
        repeat (4) step();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, k, 32'hB0 + k, 0, 0);
            step();
        end
        drive(1, 1, 0, 32'hEE, 0, 0); step(); expect_o("bp_dup", 1, 32'hB0, 4, 1);
        drive(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("bp_hold%0d_rdy", k), alloc_rdy, 0);
            expect_o($sformatf("bp_hold%0d", k), 1, 32'hB0, 4, 0);
        end
        drive(1, 0, 0, 0, 1, 0); step();
        expect_o("bp_pop", 1, 32'hB1, 3, 0);
        chk("bp_pop_rdy", alloc_rdy, 1);
        chk("bp_pop_seq", alloc_seq, 0);
        drive(1, 0, 0, 0, 0, 0); step();
        expect_o("bp_regrant", 1, 32'hB1, 4, 0);
        chk("bp_regrant_rdy", alloc_rdy, 0);
        drive(0, 1, 0, 32'hB4, 1, 0); step(); expect_o("bp_d1", 1, 32'hB2, 3, 0);
        drive(0, 0, 0, 0, 1, 0);
        step(); expect_o("bp_d2", 1, 32'hB3, 2, 0);
        step(); expect_o("bp_d3", 1, 32'hB4, 1, 0);
        step(); expect_o("bp_d4", 0, 0, 0, 0);

        // steady stream: alloc, return and pop every cycle (tags start at index 1)
        drive(1, 0, 0, 0, 0, 0); step();
        drive(1, 1, stag(0), 32'h100, 0, 0); step();
        expect_o("st_prime", 1, 32'h100, 2, 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, stag(i + 1), 32'h100 + i + 1, 1, 0);
            step();
            expect_o($sformatf("st%0d", i), 1, 32'h100 + i + 1, 2, 0);
            chk($sformatf("st%0d_out_seq", i), out_seq, stag(i + 1));
        end
        drive(0, 1, stag(21), 32'h115, 1, 0); step(); expect_o("st_dr1", 1, 32'h115, 1, 0);
        drive(0, 0, 0, 0, 1, 0); step(); expect_o("st_dr2", 0, 0, 0, 0);

        // flush with 3 allocated (tags 3,0,1), 2 done
        drive(1, 0, 0, 0, 0, 0);
        repeat (3) step();
        drive(0, 1, 3, 32'hC3, 0, 0); step();
        drive(0, 1, 0, 32'hC0, 0, 0); step();
        expect_o("fl_pre", 1, 32'hC3, 3, 0);
        drive(0, 0, 0, 0, 0, 1); step();
        expect_o("fl_post", 0, 0, 0, 0);
        chk("fl_alloc_rdy", alloc_rdy, 1);
        chk("fl_alloc_seq", alloc_seq, 0);
        drive(0, 0, 0, 0, 0, 0); step(); expect_o("fl_quiet", 0, 0, 0, 0);
        drive(0, 1, 1, 32'h77, 0, 0); step(); expect_o("fl_stale", 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0); step(); expect_o("fl_stale_end", 0, 0, 0, 0);

        // asynchronous reset mid-stream
        drive(1, 0, 0, 0, 0, 0);
        repeat (2) step();
        drive(0, 1, 0, 32'h99, 0, 0); step();
        expect_o("ar_pre", 1, 32'h99, 2, 0);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_alloc_rdy", alloc_rdy, 1);
        chk("ar_alloc_seq", alloc_seq, 0);
        chk("ar_out_seq", out_seq, 0);
        expect_o("ar", 0, 0, 0, 0);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        step();
        expect_o("ar_after", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
